// File: rtl/button_repeat_debouncer_pkg.sv
// Shared types and default 10 MHz timing constants for the button conditioner.
package button_repeat_debouncer_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD        = 3'd2,
        ST_REPEAT      = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } btn_state_e;

    localparam int unsigned DEF_CNT_W     = 23;
    localparam int unsigned DEB_10MS      = 100_000;
    localparam int unsigned REP_DLY_500MS = 5_000_000;
    localparam int unsigned REP_PER_200MS = 2_000_000;

    // Debounced level is high from acceptance until the release is confirmed.
    function automatic logic state_is_held(input btn_state_e s);
        return (s == ST_HELD) || (s == ST_REPEAT) || (s == ST_DEB_RELEASE);
    endfunction

endpackage

// File: rtl/button_repeat_debouncer_if.sv
// Raw button level in, conditioned event/level outputs back.
interface button_repeat_debouncer_if;
    logic btn_in;
    logic pulse;
    logic held;
    logic repeating;

    modport master (output btn_in, input pulse, input held, input repeating);
    modport slave  (input btn_in, output pulse, output held, output repeating);
endinterface

// File: rtl/button_repeat_debouncer_sync_2ff.sv
// Two-flop synchroniser for an asynchronous level, resets to 0.
module button_repeat_debouncer_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Metastability filter chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_repeat_debouncer.sv
// Debounces one push-button and emits press / auto-repeat strobes.
module button_repeat_debouncer
    import button_repeat_debouncer_pkg::*;
#(
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS,
    parameter int unsigned REPEAT_DELAY    = REP_DLY_500MS,
    parameter int unsigned REPEAT_PERIOD   = REP_PER_200MS,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    button_repeat_debouncer_if.slave    btn_bus
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    // Reject timing values the counter cannot represent or that allow adjacent strobes.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
        64'(DEBOUNCE_CYCLES) - 64'd1 > CNT_MAX ||
        64'(REPEAT_DELAY) - 64'd1 > CNT_MAX ||
        64'(REPEAT_PERIOD) - 64'd1 > CNT_MAX) begin : g_param_err
        $error("button_repeat_debouncer: illegal timing parameters for CNT_W");
    end

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             btn_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             held_q, held_d;
    logic             rep_q, rep_d;

    button_repeat_debouncer_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn_bus.btn_in),
        .q_o   (btn_s)
    );

    // State, shared timer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
            rep_q   <= rep_d;
        end
    end

    // Next state; a release seen on btn_s always wins over timer expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (btn_s) state_d = ST_DEB_PRESS;
            end
            ST_DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = '0;
                end else if (REPEAT_EN && cnt_q == DLY_LAST) begin
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!btn_s) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DEB_RELEASE: begin
                if (btn_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = state_is_held(state_d);
        rep_d  = (state_d == ST_REPEAT);
    end

    assign btn_bus.pulse     = pulse_q;
    assign btn_bus.held      = held_q;
    assign btn_bus.repeating = rep_q;

endmodule

// File: tb/tb_button_repeat_debouncer.sv
// Randomised and directed checks of two debouncer instances (repeat on / off) against a run-length model.
module tb_button_repeat_debouncer;

    localparam int unsigned TB_CNT_W = 5;
    localparam int unsigned TB_DEB   = 4;
    localparam int unsigned TB_DLY   = 10;
    localparam int unsigned TB_PER   = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    button_repeat_debouncer_if bus_r ();
    button_repeat_debouncer_if bus_n ();

    button_repeat_debouncer #(
        .CNT_W(TB_CNT_W), .DEBOUNCE_CYCLES(TB_DEB), .REPEAT_DELAY(TB_DLY),
        .REPEAT_PERIOD(TB_PER), .REPEAT_EN(1'b1)
    ) u_dut_r (.clk(clk), .reset(reset), .btn_bus(bus_r));

    button_repeat_debouncer #(
        .CNT_W(TB_CNT_W), .DEBOUNCE_CYCLES(TB_DEB), .REPEAT_DELAY(TB_DLY),
        .REPEAT_PERIOD(TB_PER), .REPEAT_EN(1'b0)
    ) u_dut_n (.clk(clk), .reset(reset), .btn_bus(bus_n));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_q(input string nm, input int act[$], input int exp[$]);
        check_int({nm, "_count"}, act.size(), exp.size());
        for (int k = 0; k < act.size() && k < exp.size(); k++)
            check_int({nm, "_edge"}, act[k], exp[k]);
    endtask

    // Model: index 0 = repeat enabled, 1 = repeat disabled. Tracks run lengths of the synchronised level.
    logic m_ff1 [2];
    logic m_ff2 [2];
    logic m_held[2];
    logic m_rep [2];
    logic m_pulse[2];
    int   m_press[2];
    int   m_high [2];
    int   m_low  [2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ff1[i] = 1'b0; m_ff2[i] = 1'b0;
            m_held[i] = 1'b0; m_rep[i] = 1'b0; m_pulse[i] = 1'b0;
            m_press[i] = 0; m_high[i] = 0; m_low[i] = 0;
        end
    endtask

    task automatic model_step(input logic b);
        logic s;
        for (int i = 0; i < 2; i++) begin
            s = m_ff2[i];
            m_ff2[i] = m_ff1[i];
            m_ff1[i] = b;
            m_pulse[i] = 1'b0;
            if (!m_held[i]) begin
                // Accept after DEB+1 consecutive high samples (one to leave idle, DEB to time out).
                if (s) begin
                    m_press[i]++;
                    if (m_press[i] == int'(TB_DEB) + 1) begin
                        m_held[i] = 1'b1; m_pulse[i] = 1'b1;
                        m_press[i] = 0; m_high[i] = 0; m_low[i] = 0;
                    end
                end else begin
                    m_press[i] = 0;
                end
            end else if (!s) begin
                m_low[i]++;
                m_high[i] = 0;
                m_rep[i] = 1'b0;
                if (m_low[i] == int'(TB_DEB) + 1) begin
                    m_held[i] = 1'b0; m_low[i] = 0;
                end
            end else if (m_low[i] > 0) begin
                m_low[i] = 0; m_high[i] = 0;
            end else begin
                m_high[i]++;
                if (i == 0) begin
                    if (!m_rep[i] && m_high[i] == int'(TB_DLY)) begin
                        m_pulse[i] = 1'b1; m_rep[i] = 1'b1; m_high[i] = 0;
                    end else if (m_rep[i] && m_high[i] == int'(TB_PER)) begin
                        m_pulse[i] = 1'b1; m_high[i] = 0;
                    end
                end
            end
        end
    endtask

    bit   cmp_en = 1'b0;
    logic prev_r = 1'b0;
    logic prev_n = 1'b0;

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check_int("pulse_r", int'(bus_r.pulse), int'(m_pulse[0]));
            check_int("held_r",  int'(bus_r.held),  int'(m_held[0]));
            check_int("rep_r",   int'(bus_r.repeating), int'(m_rep[0]));
            check_int("pulse_n", int'(bus_n.pulse), int'(m_pulse[1]));
            check_int("held_n",  int'(bus_n.held),  int'(m_held[1]));
            check_int("rep_n",   int'(bus_n.repeating), int'(m_rep[1]));
            check_int("adjacent_r", int'(prev_r & bus_r.pulse), 0);
            check_int("adjacent_n", int'(prev_n & bus_n.pulse), 0);
        end
        prev_r = bus_r.pulse;
        prev_n = bus_n.pulse;
    end

    int edge_n = 0;
    int q_r[$];
    int q_n[$];
    int exp_q[$];

    task automatic step(input logic b);
        bus_r.btn_in = b;
        bus_n.btn_in = b;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(b);
        edge_n++;
        @(negedge clk);
        #1;
        if (bus_r.pulse) q_r.push_back(edge_n);
        if (bus_n.pulse) q_n.push_back(edge_n);
    endtask

    task automatic steps(input logic b, input int n);
        for (int k = 0; k < n; k++) step(b);
    endtask

    task automatic start_scenario();
        edge_n = 0;
        q_r.delete();
        q_n.delete();
    endtask

    initial begin
        bus_r.btn_in = 1'b0;
        bus_n.btn_in = 1'b0;
        model_reset();
        steps(1'b0, 2);
        reset = 1'b0;
        cmp_en = 1'b1;
        check_int("reset_held", int'(bus_r.held), 0);
        check_int("reset_pulse", int'(bus_r.pulse), 0);
        steps(1'b0, 4);

        // Clean press held for 8 cycles.
        start_scenario();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1);
            if (k == 6) check_int("t1_pulse_e6", int'(bus_r.pulse), 0);
            if (k == 7) begin
                check_int("t1_pulse_e7", int'(bus_r.pulse), 1);
                check_int("t1_held_e7", int'(bus_r.held), 1);
            end
            if (k == 8) check_int("t1_pulse_e8", int'(bus_r.pulse), 0);
        end
        steps(1'b0, 12);
        exp_q = '{7};
        check_q("t1_pulses", q_r, exp_q);
        check_int("t1_held_end", int'(bus_r.held), 0);

        // Short glitches are rejected.
        start_scenario();
        step(1'b1); steps(1'b0, 2);
        steps(1'b1, 2); steps(1'b0, 2);
        steps(1'b1, 3); steps(1'b0, 8);
        check_int("t2_pulses", q_r.size() + q_n.size(), 0);
        check_int("t2_held", int'(bus_r.held), 0);

        // Long hold with auto-repeat.
        start_scenario();
        for (int k = 1; k <= 30; k++) begin
            step(1'b1);
            if (k == 17) check_int("t3_rep_e17", int'(bus_r.repeating), 1);
            if (k == 16) check_int("t3_rep_e16", int'(bus_r.repeating), 0);
        end
        exp_q = '{7, 17, 20, 23, 26, 29};
        check_q("t3_pulses_r", q_r, exp_q);
        exp_q = '{7};
        check_q("t3_pulses_n", q_n, exp_q);
        steps(1'b0, 10);

        // Two-cycle low glitch while held restarts the repeat delay.
        start_scenario();
        for (int k = 1; k <= 30; k++) begin
            step((k == 13 || k == 14) ? 1'b0 : 1'b1);
            if (k == 15 || k == 16) check_int("t4_held_glitch", int'(bus_r.held), 1);
        end
        exp_q = '{7, 27, 30};
        check_q("t4_pulses_r", q_r, exp_q);
        steps(1'b0, 10);

        // Repeat disabled: one pulse for a 40-cycle hold, counter saturates silently.
        start_scenario();
        steps(1'b1, 40);
        exp_q = '{7};
        check_q("t5_pulses_n", q_n, exp_q);
        check_int("t5_held_n", int'(bus_n.held), 1);
        steps(1'b0, 10);

        // Asynchronous reset in the repeat phase, then a fresh press.
        start_scenario();
        steps(1'b1, 18);
        check_int("t6_rep_before", int'(bus_r.repeating), 1);
        reset = 1'b1;
        model_reset();
        #1;
        check_int("t6_rst_held_r", int'(bus_r.held), 0);
        check_int("t6_rst_rep_r", int'(bus_r.repeating), 0);
        check_int("t6_rst_held_n", int'(bus_n.held), 0);
        steps(1'b1, 2);
        reset = 1'b0;
        start_scenario();
        steps(1'b1, 10);
        exp_q = '{7};
        check_q("t6_pulses_r", q_r, exp_q);
        steps(1'b0, 10);

        // Random bouncing levels and holds.
        for (int r = 0; r < 250; r++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 45))
                                              : int'($urandom_range(1, 7));
            steps(r[0] ? 1'b0 : 1'b1, len);
        end
        steps(1'b0, 10);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
